// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 key tracker.
//                Holds the scan-code parser state encoding, the PS/2 prefix
//                and shift scan codes, and the 10-bit key event record.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Scan-code parser states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Key event as stored in the event FIFO
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Key is {ext, code}; only the non-extended left/right shift codes count
    function automatic logic is_shift_key(input logic [8:0] key);
        return (key == {1'b0, SC_LSHIFT}) || (key == {1'b0, SC_RSHIFT});
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_event_fifo
//  Description : First-word-fall-through FIFO of key events.
//                A push while full is dropped (sticky o_drop) unless a pop
//                happens in the same cycle, in which case both succeed.
//                A pop while empty is ignored. Head data reads as zero when
//                the FIFO is empty.
//  Ports       : clk, rstn (async active-low)
//                i_push/i_data  - write side
//                i_pop          - consume head when o_valid
//                o_valid/o_data - head of queue
//                o_drop         - sticky event-lost flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_push,
    input  ps2_event_t i_data,
    input  logic       i_pop,
    output logic       o_valid,
    output ps2_event_t o_data,
    output logic       o_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(FIFO_DEPTH);

    ps2_event_t  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_drop;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_do_pop  = i_pop & ~w_empty;
    // When full, the slot being freed by a same-cycle pop is the one written
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_do_push) r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_drop  = r_drop;

endmodule : ps2_event_fifo
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_tracker
//  Description : Consumes PS/2 scan bytes, parses E0/F0 prefixes, keeps a
//                table of currently held keys, counts new presses and queues
//                press/release events in a FWFT FIFO.
//  Ports       : clk, rstn (async active-low)
//                in_data/in_ready/nextdata_n - byte handshake with receiver
//                ev_valid/ev_ready/ev_code/ev_ext/ev_break - event stream
//                held_cnt, press_cnt, shift_held - key status
//                ev_drop, tbl_ovf - sticky loss flags
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int MAX_KEYS      = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_W         = 8,
    parameter int REPORT_REPEAT = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       in_data,
    input  logic             in_ready,
    output logic             nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [3:0]       held_cnt,
    output logic [CNT_W-1:0] press_cnt,
    output logic             shift_held,
    output logic             ev_drop,
    output logic             tbl_ovf
);

    localparam logic c_repeat_en = (REPORT_REPEAT != 0);

    // ------------------------------------------------------------------
    // Byte handshake: r_ack is high for the single cycle after an accept
    // ------------------------------------------------------------------
    logic r_ack;
    logic w_accept;

    assign w_accept   = in_ready & ~r_ack;
    assign nextdata_n = ~r_ack;

    // ------------------------------------------------------------------
    // Prefix decode
    // ------------------------------------------------------------------
    ps2_state_t r_state;
    ps2_state_t w_state_nxt;
    logic       w_is_make;
    logic       w_is_brk;
    logic       w_ext;
    logic [8:0] w_key;

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_is_make   = 1'b0;
        w_is_brk    = 1'b0;
        w_ext       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_data == SC_EXT)      w_state_nxt = ST_EXT;
                else if (in_data == SC_BRK) w_state_nxt = ST_BRK;
                else                        w_is_make   = 1'b1;
            end
            ST_EXT: begin
                // Repeated E0 keeps the extended context
                if (in_data == SC_BRK)      w_state_nxt = ST_EXT_BRK;
                else if (in_data == SC_EXT) w_state_nxt = ST_EXT;
                else begin
                    w_is_make = 1'b1;
                    w_ext     = 1'b1;
                end
            end
            ST_BRK: begin
                w_is_brk = 1'b1;
            end
            ST_EXT_BRK: begin
                w_is_brk = 1'b1;
                w_ext    = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_key = {w_ext, in_data};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Held-key table
    // ------------------------------------------------------------------
    logic [MAX_KEYS-1:0] r_valid;
    logic [8:0]          r_key [MAX_KEYS];

    logic [MAX_KEYS-1:0] w_hit;
    logic [MAX_KEYS-1:0] w_free;
    logic [MAX_KEYS-1:0] w_free_first;
    logic [MAX_KEYS-1:0] w_set;
    logic [MAX_KEYS-1:0] w_clr;
    logic [MAX_KEYS-1:0] w_valid_nxt;
    logic                w_any_hit;
    logic                w_tbl_full;
    logic                w_new_press;
    logic                w_ovf;
    logic                w_repeat;
    logic                w_release;
    logic                w_push;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            w_hit[i] = r_valid[i] && (r_key[i] == w_key);
        end
    end

    assign w_free       = ~r_valid;
    // Isolate the lowest set bit of the free mask
    assign w_free_first = w_free & (~w_free + MAX_KEYS'(1));
    assign w_any_hit    = |w_hit;
    assign w_tbl_full   = &r_valid;

    assign w_new_press = w_accept & w_is_make & ~w_any_hit & ~w_tbl_full;
    assign w_ovf       = w_accept & w_is_make & ~w_any_hit &  w_tbl_full;
    assign w_repeat    = w_accept & w_is_make &  w_any_hit;
    assign w_release   = w_accept & w_is_brk;
    assign w_push      = w_new_press | w_release | (w_repeat & c_repeat_en);

    assign w_set       = w_new_press ? w_free_first : '0;
    assign w_clr       = w_release   ? w_hit        : '0;
    assign w_valid_nxt = (r_valid & ~w_clr) | w_set;

    // Status is computed from the post-update table so it lands one cycle
    // after the accepting edge
    logic [3:0] w_held_nxt;
    logic       w_shift_nxt;

    always_comb begin
        w_held_nxt  = '0;
        w_shift_nxt = 1'b0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (w_valid_nxt[i]) begin
                w_held_nxt = w_held_nxt + 4'd1;
                if (is_shift_key(w_set[i] ? w_key : r_key[i])) w_shift_nxt = 1'b1;
            end
        end
    end

    logic [3:0]       r_held_cnt;
    logic             r_shift_held;
    logic [CNT_W-1:0] r_press_cnt;
    logic             r_tbl_ovf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid      <= '0;
            for (int i = 0; i < MAX_KEYS; i++) r_key[i] <= '0;
            r_held_cnt   <= '0;
            r_shift_held <= 1'b0;
            r_press_cnt  <= '0;
            r_tbl_ovf    <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            for (int i = 0; i < MAX_KEYS; i++) begin
                if (w_set[i]) r_key[i] <= w_key;
            end
            r_held_cnt   <= w_held_nxt;
            r_shift_held <= w_shift_nxt;
            if (w_new_press) r_press_cnt <= r_press_cnt + CNT_W'(1);
            if (w_ovf)       r_tbl_ovf   <= 1'b1;
        end
    end

    assign held_cnt   = r_held_cnt;
    assign shift_held = r_shift_held;
    assign press_cnt  = r_press_cnt;
    assign tbl_ovf    = r_tbl_ovf;

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    ps2_event_t w_ev_in;
    ps2_event_t w_ev_head;

    assign w_ev_in = '{ext: w_ext, brk: w_is_brk, code: in_data};

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_ev_in),
        .i_pop   (ev_ready),
        .o_valid (ev_valid),
        .o_data  (w_ev_head),
        .o_drop  (ev_drop)
    );

    assign ev_code  = w_ev_head.code;
    assign ev_ext   = w_ev_head.ext;
    assign ev_break = w_ev_head.brk;

endmodule : ps2_key_tracker
`default_nettype wire

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter MAX_KEYS, default 4, size of the held-key table (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, depth of the key-event FIFO (power of 2, >=2).
REQ-003 SHALL have parameter CNT_W, default 8, width of the press counter.
REQ-004 SHALL have parameter REPORT_REPEAT, default 0; when 1, typematic repeats generate events.
REQ-005 SHALL have ports as follows, clock and reset first:
- clk  input  1  sole clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_data  input  8  scan byte from PS/2 receiver.
- in_ready  input  1  receiver has a byte available.
- nextdata_n  output  1  active-low one-cycle byte acknowledge to receiver.
- ev_valid  output  1  event FIFO non-empty.
- ev_ready  input  1  consumer pops head when ev_valid & ev_ready.
- ev_code  output  8  head event scan code.
- ev_ext  output  1  head event had E0 prefix.
- ev_break  output  1  head event is release (1) or press (0).
- held_cnt  output  4  number of valid table entries.
- press_cnt  output  CNT_W  count of new presses.
- shift_held  output  1  code 0x12 or 0x59 (non-ext) present in table.
- ev_drop  output  1  sticky: an event was lost to FIFO full.
- tbl_ovf  output  1  sticky: a new press was lost to table full.

Function
REQ-006 SHALL accept a byte in the cycle where in_ready=1 and nextdata_n=1; nextdata_n SHALL be 0 in the following cycle only, and 1 otherwise; no byte SHALL be accepted while nextdata_n=0.
REQ-007 SHALL parse with FSM states IDLE, EXT, BRK, EXT_BRK; all states SHALL return to IDLE after a non-prefix byte.
REQ-008 IDLE: E0->EXT, F0->BRK, other byte -> make(ext=0). EXT: F0->EXT_BRK, E0->stay EXT, other -> make(ext=1). BRK: any byte -> break(ext=0). EXT_BRK: any byte -> break(ext=1).
REQ-009 A make with key {ext,code} absent from the table SHALL insert it in the lowest free slot, increment press_cnt, and push a press event, all in the accept cycle.
REQ-010 A make with key already present SHALL not change table or press_cnt, and SHALL push a press event only if REPORT_REPEAT=1.
REQ-011 A make with key absent and table full SHALL set tbl_ovf, push no event, leave press_cnt unchanged.
REQ-012 A break SHALL clear the matching entry if present and always push a release event.
REQ-013 press_cnt SHALL wrap modulo 2^CNT_W.
REQ-014 held_cnt and shift_held SHALL reflect table contents registered, one cycle after the accept cycle.
REQ-015 FIFO SHALL be first-word-fall-through; ev_code/ev_ext/ev_break valid whenever ev_valid=1, ev_valid SHALL rise the cycle after the first push.
REQ-016 Push when full without same-cycle pop SHALL drop the event and set ev_drop; push and pop in the same cycle when full SHALL both succeed.
REQ-017 Pop when empty SHALL be ignored.

Reset
REQ-018 rstn=0 SHALL immediately set FSM to IDLE, clear table, FIFO pointers, press_cnt, ev_drop, tbl_ovf; outputs: nextdata_n=1, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, held_cnt=0, shift_held=0.
REQ-019 Reset mid-sequence (after E0 or F0) SHALL discard the pending prefix.

Structure
REQ-020 Package ps2_pkg SHALL hold the FSM state enum, constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, and the 10-bit event struct {ext, brk, code}.
REQ-021 The event FIFO SHALL be a sub-module ps2_event_fifo parameterised by FIFO_DEPTH.

Verification
REQ-022 Bytes 1C, F0, 1C -> press{0,1C} then release{0,1C}; press_cnt=1; held_cnt 1 then 0.
REQ-023 Bytes E0 75, E0 F0 75 -> press{ext=1,75}, release{ext=1,75}; no event with code E0/F0.
REQ-024 Bytes 1C 1C 1C (REPORT_REPEAT=0) -> one event, press_cnt=1; with REPORT_REPEAT=1 -> three events, press_cnt=1.
REQ-025 MAX_KEYS=4, makes 15 1D 24 2D 2C -> tbl_ovf=1, held_cnt=4, press_cnt=4, four events.
REQ-026 ev_ready=0, 9 distinct make/break events with FIFO_DEPTH=8 -> ev_drop=1, 8 events popped in order once ev_ready=1.
REQ-027 Bytes 12 then rstn pulse low mid-way through F0 12 -> after reset all outputs at REQ-018 values, next byte 12 treated as make.
